// File: rtl/midi_button_encoder.sv
// Turns debounced button press pulses into MIDI Note On messages over a valid/ready byte link.
// Optional build macro MIDI_RUNNING_STATUS_EN drops repeated status bytes (running status).
module midi_button_encoder #(
  parameter int NUM_BTN    = 4,
  parameter int CHANNEL    = 0,
  parameter int BASE_NOTE  = 60,
  parameter int VELOCITY   = 100,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raised,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               overflow,
  output logic               busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [7:0] STATUS_BYTE = {4'h9, 4'(CHANNEL)};
  localparam logic [7:0] VEL_BYTE    = {1'b0, 7'(VELOCITY)};

  typedef enum logic [1:0] {IDLE, STATUS, NOTE, VEL} state_t;

  state_t             state_q, state_d;
  logic [NUM_BTN-1:0] pending_q, pending_d, clr_mask, drop_mask;
  logic [AW:0]        wr_ptr_q, rd_ptr_q;
  logic [3:0]         fifo_mem [FIFO_DEPTH];
  logic [3:0]         fifo_head, idx_q, idx_d, grant_idx;
  logic               grant_vld, push, pop, fifo_empty, fifo_full, hs;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d, overflow_q, busy_q, busy_d;
`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0]         last_status_q, last_status_d;
`endif

  function automatic logic [7:0] note_byte(input logic [3:0] idx);
    return {1'b0, 7'(BASE_NOTE) + 7'(idx)};
  endfunction

  // Fixed-priority grant: lowest set pending bit wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        grant_vld = 1'b1;
        grant_idx = 4'(i);
      end
    end
  end

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fifo_head  = fifo_mem[rd_ptr_q[AW-1:0]];
  assign push       = grant_vld && !fifo_full;

  generate
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_pend
      assign clr_mask[gi]  = push && (grant_idx == 4'(gi));
      assign drop_mask[gi] = btn_raised[gi] && pending_q[gi] && !clr_mask[gi];
      assign pending_d[gi] = btn_raised[gi] || (pending_q[gi] && !clr_mask[gi]);
    end
  endgenerate

  assign hs     = tx_valid_q && tx_ready;
  assign busy_d = (|pending_q) || !fifo_empty || (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    pop        = 1'b0;
`ifdef MIDI_RUNNING_STATUS_EN
    last_status_d = last_status_q;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          idx_d      = fifo_head;
          tx_valid_d = 1'b1;
`ifdef MIDI_RUNNING_STATUS_EN
          if (last_status_q == STATUS_BYTE) begin
            state_d   = NOTE;
            tx_data_d = note_byte(fifo_head);
          end else begin
            state_d   = STATUS;
            tx_data_d = STATUS_BYTE;
          end
`else
          state_d   = STATUS;
          tx_data_d = STATUS_BYTE;
`endif
        end
      end
      STATUS: begin
        if (hs) begin
          state_d   = NOTE;
          tx_data_d = note_byte(idx_q);
`ifdef MIDI_RUNNING_STATUS_EN
          last_status_d = STATUS_BYTE;
`endif
        end
      end
      NOTE: begin
        if (hs) begin
          state_d   = VEL;
          tx_data_d = VEL_BYTE;
        end
      end
      VEL: begin
        if (hs) begin
          state_d    = IDLE;
          tx_valid_d = 1'b0;
        end
      end
      default: begin
        state_d    = IDLE;
        tx_valid_d = 1'b0;
      end
    endcase
  end

  // Queue storage carries no reset; only the pointers define its contents.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= grant_idx;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      idx_q      <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef MIDI_RUNNING_STATUS_EN
      last_status_q <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      wr_ptr_q   <= wr_ptr_q + (AW + 1)'(push);
      rd_ptr_q   <= rd_ptr_q + (AW + 1)'(pop);
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      overflow_q <= |drop_mask;
      busy_q     <= busy_d;
`ifdef MIDI_RUNNING_STATUS_EN
      last_status_q <= last_status_d;
`endif
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign overflow = overflow_q;
  assign busy     = busy_q;

endmodule
